// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int FETCH_PC_W = 32;
  localparam int FETCH_INSTR_W = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]    pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               wr_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t       mem_r [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               full_s;
  logic               empty_s;
  logic               do_push_s;
  logic               do_pop_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign do_push_s = push && (!full_s || pop) && !flush;
  assign do_pop_s  = pop && !empty_s && !flush;

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_r <= wr_ptr_r;
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry reads as zero while empty so stale data never leaks out.
  always_comb begin
    rd_data = '0;
    if (empty_s) begin
      rd_data = '0;
    end else begin
      rd_data = mem_r[rd_ptr_r];
    end
  end

  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, fetch FIFO and branch redirect.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    DEPTH        = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_instr,
  input  logic                  pc_src,
  input  logic [31:0]           imm_op,
  output logic [31:0]           stat_fetches,
  output logic [31:0]           stat_redirects
);

  logic [ADDR_WIDTH-1:0]   fetch_pc_r;
  logic [ADDR_WIDTH-1:0]   target_sum_s;
  logic [ADDR_WIDTH-1:0]   redirect_pc_s;
  fetch_entry_t            wr_entry_s;
  fetch_entry_t            head_s;
  logic [$clog2(DEPTH):0]  fifo_count_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic                    pop_s;
  logic                    redirect_s;
  logic                    push_s;
  logic                    unused_s;

  assign out_valid  = !fifo_empty_s;
  assign pop_s      = out_valid && out_ready;
  assign redirect_s = pop_s && pc_src;
  assign push_s     = (!fifo_full_s || pop_s) && !redirect_s;

  assign imem_addr  = fetch_pc_r;
  assign out_pc     = head_s.pc[ADDR_WIDTH-1:0];
  assign out_instr  = head_s.instr[DATA_WIDTH-1:0];

  // Branch targets are word aligned regardless of the offset's low bits.
  assign target_sum_s  = out_pc + ADDR_WIDTH'(imm_op);
  assign redirect_pc_s = {target_sum_s[ADDR_WIDTH-1:2], 2'b00};

  assign wr_entry_s.pc    = FETCH_PC_W'(fetch_pc_r);
  assign wr_entry_s.instr = FETCH_INSTR_W'(imem_rdata);

  assign unused_s = ^{fifo_count_s, head_s};

  // Program counter: redirect, sequential advance, or hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r <= RESET_VECTOR;
    end else if (redirect_s) begin
      fetch_pc_r <= redirect_pc_s;
    end else if (push_s) begin
      fetch_pc_r <= fetch_pc_r + ADDR_WIDTH'(INSTR_BYTES);
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .wr_data (wr_entry_s),
    .pop     (pop_s),
    .flush   (redirect_s),
    .rd_data (head_s),
    .count   (fifo_count_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetches_r;
  logic [31:0] stat_redirects_r;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetches_r   <= 32'h0000_0000;
      stat_redirects_r <= 32'h0000_0000;
    end else begin
      if (push_s && (stat_fetches_r != 32'hFFFF_FFFF)) begin
        stat_fetches_r <= stat_fetches_r + 32'h0000_0001;
      end
      if (redirect_s && (stat_redirects_r != 32'hFFFF_FFFF)) begin
        stat_redirects_r <= stat_redirects_r + 32'h0000_0001;
      end
    end
  end

  assign stat_fetches   = stat_fetches_r;
  assign stat_redirects = stat_redirects_r;
`else
  assign stat_fetches   = 32'h0000_0000;
  assign stat_redirects = 32'h0000_0000;
`endif

endmodule
